regfile_multiport: RTL
======================

Name: regfile_multiport

Overview:
- Parametrised register file: one synchronous write port, NUM_READ independent read ports.
- Each read port uses a one-hot decode and select mux. Replaces the fixed 32x32 single-read-port decode/tristate read path in the processor datapath.
- Adds optional registered read outputs, write-to-read bypass, a hardwired-zero register 0, and a synchronous clear.
- Sits between decode and execute; also serves as the game-state scratch bank.

Parameters:
- WIDTH, 32, data bits per register.
- DEPTH, 32, number of registers; must be >= 2. ADDR_W = clog2(DEPTH).
- NUM_READ, 2, number of read ports, 1..4.
- REG_OUT, 0: 0 = combinational read (0-cycle); 1 = registered read (1-cycle latency).
- BYPASS, 1: 1 = write data is forwarded to a same-cycle read of the same address.
- ZERO_REG, 1: 1 = register 0 reads as 0 and ignores writes.

Ports:
- clock  in  1  single clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high; clears all registers and read pipeline.
- we  in  1  write enable.
- waddr  in  ADDR_W  write address.
- wdata  in  WIDTH  write data.
- re  in  NUM_READ  per-port read enable; used only when REG_OUT=1.
- raddr  in  NUM_READ*ADDR_W  packed read addresses; port k is at [k*ADDR_W +: ADDR_W].
- rdata  out  NUM_READ*WIDTH  packed read data; port k is at [k*WIDTH +: WIDTH].
- rvalid  out  NUM_READ  port k holds fresh data for its last enabled request (REG_OUT=1); tied 1 when REG_OUT=0.
- clear  in  1  synchronous clear of all registers; does not affect the read pipeline.

Behaviour:
- Reset is synchronous and active-high; the block runs on one clock. Reset is sampled at the clock edge. After reset:
  - all registers = 0;
  - rdata = 0 and rvalid = 0 when REG_OUT=1;
  - rdata = 0 (all registers read 0) when REG_OUT=0.
- Reset takes priority over clear; clear takes priority over we.
- Write: on edge with we=1 and waddr < DEPTH, reg[waddr] <= wdata.
  - waddr >= DEPTH (non-power-of-2 DEPTH): write is dropped.
  - ZERO_REG=1 and waddr=0: write is dropped.
- Read data selection for port k (value "sel_k"):
  - decode raddr_k to one-hot of DEPTH bits, then AND-OR select; no internal tristates;
  - raddr_k >= DEPTH gives 0;
  - ZERO_REG=1 and raddr_k=0 gives 0 regardless of bypass.
- Bypass: BYPASS=1 and we=1 and waddr==raddr_k (and not the zero-reg case) gives sel_k = wdata.
  - BYPASS=0: sel_k = current stored value (old data).
- REG_OUT=0: rdata_k = sel_k combinationally; re is ignored.
- REG_OUT=1, on each edge:
  - re_k=1: rdata_k <= sel_k and rvalid_k <= 1;
  - re_k=0: rdata_k holds and rvalid_k <= 0.
  - Result: data requested in cycle N appears in cycle N+1.
- Simultaneous reads of the same address on several ports: each port returns the identical value.
- clear and we in the same cycle: all registers = 0 and the write is lost. A read in that cycle still sees the pre-clear value (or bypassed wdata).
- Reset asserted mid-stream with REG_OUT=1: the next cycle shows rvalid = 0 and rdata = 0. Requests issued during reset are discarded.
- No write-write conflicts are possible (single write port).

Decomposition:
- Shared package regfile_pkg:
  - clog2 function;
  - packed-slice helper macros/functions for port k;
  - MAX_READ = 4 constant.
- Sub-module onehot_read_mux, parametrised WIDTH/DEPTH/ADDR_W:
  - inputs: flat register array, address, bypass hit and wdata;
  - output: sel;
  - instantiated NUM_READ times in a generate loop.
- Top-level holds the register array, write logic, clear/reset, and the optional output register stage.

Test Plan:
- Reset/readback: assert reset 2 cycles, read all addresses on both ports -> every rdata = 0x00000000; rvalid = 0 on the first post-reset cycle (REG_OUT=1).
- Write/read: write 0xDEADBEEF to reg 5, next cycle read port0 = 5 and port1 = 5 -> both 0xDEADBEEF (REG_OUT=0 same cycle; REG_OUT=1 one cycle later with rvalid = 1).
- Bypass: write 0x12345678 to reg 9 while port1 reads 9, reg 9 previously 0x1 -> port1 = 0x12345678 if BYPASS=1, 0x00000001 if BYPASS=0.
- Zero register: write 0xFFFFFFFF to reg 0 while port0 reads 0 -> port0 = 0 in that cycle and all later cycles (ZERO_REG=1).
- Clear vs write: regs 1..3 = 0xA, 0xB, 0xC; assert clear and we (reg 2, 0x77) together -> next cycle regs 1..3 = 0; read in the clear cycle returns 0xA/0x77/0xC.
- Parameter sweep: DEPTH=20, NUM_READ=3, WIDTH=16, with random writes/reads vs scoreboard -> exact match; raddr = 25 returns 0; waddr = 25 leaves all registers unchanged.

Source files
------------

// File: rtl/regfile_pkg.sv
// Shared constants and helpers for the multiport register file.
package regfile_pkg;

  localparam int unsigned MAX_READ = 4;

  // Address width for a register count; at least one bit.
  function automatic int unsigned clog2(input int unsigned value);
    int unsigned r;
    int unsigned v;
    r = 0;
    v = (value > 0) ? value - 1 : 0;
    while (v > 0) begin
      r++;
      v = v >> 1;
    end
    return (r == 0) ? 1 : r;
  endfunction

  // Low bit of port k's field in a packed per-port bus.
  function automatic int unsigned slice_lo(input int unsigned port, input int unsigned width);
    return port * width;
  endfunction

endpackage

// File: rtl/regfile_multiport_mux.sv
// One read port: one-hot address decode feeding an AND-OR select, with bypass override.
module onehot_read_mux #(
  parameter int unsigned WIDTH  = 32,
  parameter int unsigned DEPTH  = 32,
  parameter int unsigned ADDR_W = 5
) (
  input  logic [DEPTH*WIDTH-1:0] regs,
  input  logic [ADDR_W-1:0]      addr,
  input  logic                   byp_hit,
  input  logic [WIDTH-1:0]       wdata,
  output logic [WIDTH-1:0]       sel
);

  logic [DEPTH-1:0] onehot;

  // Decode address; unmapped addresses leave every select line low.
  always_comb begin
    onehot = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      onehot[i] = (addr == ADDR_W'(i));
    end
  end

  // AND-OR select of the addressed register, replaced by write data on a bypass hit.
  always_comb begin
    sel = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      sel = sel | (regs[i*WIDTH +: WIDTH] & {WIDTH{onehot[i]}});
    end
    if (byp_hit) begin
      sel = wdata;
    end
  end

endmodule

// File: rtl/regfile_multiport.sv
// Register file: one synchronous write port, NUM_READ one-hot-muxed read ports,
// optional registered outputs, write bypass, hardwired zero register, sync clear.
module regfile_multiport
  import regfile_pkg::*;
#(
  parameter int unsigned WIDTH    = 32,
  parameter int unsigned DEPTH    = 32,
  parameter int unsigned NUM_READ = 2,
  parameter bit          REG_OUT  = 1'b0,
  parameter bit          BYPASS   = 1'b1,
  parameter bit          ZERO_REG = 1'b1,
  parameter int unsigned ADDR_W   = clog2(DEPTH)
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       we,
  input  logic [ADDR_W-1:0]          waddr,
  input  logic [WIDTH-1:0]           wdata,
  input  logic [NUM_READ-1:0]        re,
  input  logic [NUM_READ*ADDR_W-1:0] raddr,
  output logic [NUM_READ*WIDTH-1:0]  rdata,
  output logic [NUM_READ-1:0]        rvalid,
  input  logic                       clear
);

  logic [DEPTH-1:0][WIDTH-1:0]    mem_d, mem_q;
  logic [NUM_READ-1:0][WIDTH-1:0] sel;

  // Next register contents: clear wins over write; unmapped and zero-register writes are dropped.
  always_comb begin
    mem_d = mem_q;
    if (clear) begin
      mem_d = '0;
    end else if (we) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        if ((waddr == ADDR_W'(i)) && !(ZERO_REG && (i == 0))) begin
          mem_d[i] = wdata;
        end
      end
    end
  end

  // Register array with synchronous reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      mem_q <= '0;
    end else begin
      mem_q <= mem_d;
    end
  end

  for (genvar k = 0; k < NUM_READ; k++) begin : g_port
    logic [ADDR_W-1:0] raddr_k;
    logic              byp_hit;

    assign raddr_k = raddr[slice_lo(k, ADDR_W) +: ADDR_W];

    // Forward write data unless the read targets the hardwired zero or an unmapped address.
    always_comb begin
      byp_hit = 1'b0;
      if (BYPASS && we && (waddr == raddr_k) && (32'(raddr_k) < DEPTH) &&
          !(ZERO_REG && (raddr_k == '0))) begin
        byp_hit = 1'b1;
      end
    end

    onehot_read_mux #(
      .WIDTH (WIDTH),
      .DEPTH (DEPTH),
      .ADDR_W(ADDR_W)
    ) u_mux (
      .regs   (mem_q),
      .addr   (raddr_k),
      .byp_hit(byp_hit),
      .wdata  (wdata),
      .sel    (sel[k])
    );
  end

  if (REG_OUT) begin : g_reg_out
    logic [NUM_READ-1:0][WIDTH-1:0] rdata_d, rdata_q;
    logic [NUM_READ-1:0]            rvalid_d, rvalid_q;

    // Enabled ports capture their selection; idle ports hold data and drop valid.
    always_comb begin
      rdata_d  = rdata_q;
      rvalid_d = '0;
      for (int unsigned k = 0; k < NUM_READ; k++) begin
        if (re[k]) begin
          rdata_d[k]  = sel[k];
          rvalid_d[k] = 1'b1;
        end
      end
    end

    // Read output stage; reset discards any request in flight.
    always_ff @(posedge clock) begin
      if (reset) begin
        rdata_q  <= '0;
        rvalid_q <= '0;
      end else begin
        rdata_q  <= rdata_d;
        rvalid_q <= rvalid_d;
      end
    end

    assign rdata  = rdata_q;
    assign rvalid = rvalid_q;
  end else begin : g_comb_out
    logic unused_re;
    assign unused_re = ^re;
    assign rdata     = sel;
    assign rvalid    = '1;
  end

endmodule
